// File: rtl/tof_sequencer_pkg.sv
// ============================================================================
//  tof_sequencer_pkg
//  Shared FSM encoding, gate-entry field slots and default sizes.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package tof_sequencer_pkg;

    localparam int DEFAULT_W     = 8;
    localparam int DEFAULT_DEPTH = 8;

    // Gate entry is {t, c1, c0}; each field is log2(W) bits wide at slot*log2(W).
    localparam int C0_FIELD = 0;
    localparam int C1_FIELD = 1;
    localparam int T_FIELD  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tof_sequencer_tof.sv
// ============================================================================
//  tof
//  Three-bit Toffoli gate: a = {t, c1, c0}, y = {t ^ (c1 & c0), c1, c0}.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tof (
    input  logic [2:0] a,
    output logic [2:0] y
);

    assign y = {a[2] ^ (a[1] & a[0]), a[1], a[0]};

endmodule

`default_nettype wire

// File: rtl/tof_sequencer.sv
// ============================================================================
//  tof_sequencer
//  Applies a stored list of Toffoli gates, one per cycle, to a state register.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tof_sequencer
    import tof_sequencer_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ld_gate,
    input  logic [$clog2(DEPTH)-1:0]    ld_addr,
    input  logic [3*$clog2(W)-1:0]      gate_in,
    input  logic                        ld_data,
    input  logic [W-1:0]                data_in,
    input  logic [$clog2(DEPTH):0]      len,
    input  logic                        dir,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [W-1:0]                data_out
);

    localparam int LW = $clog2(W);
    localparam int LD = $clog2(DEPTH);

    state_t              state;
    state_t              state_nx;
    logic [W-1:0]        s;
    logic [3*LW-1:0]     glist [DEPTH];
    logic [LD-1:0]       pc;
    logic [LD:0]         run_len;
    logic                run_dir;
    logic                err_r;

    logic [LD:0]         len_sat;
    logic [3*LW-1:0]     entry;
    logic [LW-1:0]       t_idx;
    logic [LW-1:0]       c1_idx;
    logic [LW-1:0]       c0_idx;
    logic                gate_illegal;
    logic                last_gate;
    logic [2:0]          tof_in;
    logic [2:0]          tof_y;
    logic [1:0]          unused_tof_ctrl;

    assign len_sat = (len > (LD+1)'(DEPTH)) ? (LD+1)'(DEPTH) : len;

    assign entry  = glist[pc];
    assign t_idx  = entry[T_FIELD*LW  +: LW];
    assign c1_idx = entry[C1_FIELD*LW +: LW];
    assign c0_idx = entry[C0_FIELD*LW +: LW];

    assign gate_illegal = (t_idx == c0_idx) || (t_idx == c1_idx) ||
                          ({1'b0, pc} >= run_len);
    assign last_gate    = run_dir ? (pc == '0)
                                  : ({1'b0, pc} == run_len - (LD+1)'(1));

    assign tof_in = {s[t_idx], s[c1_idx], s[c0_idx]};

    tof u_tof (
        .a (tof_in),
        .y (tof_y)
    );

    // Control bits pass through the gate unchanged; only the target is written back.
    assign unused_tof_ctrl = tof_y[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (len_sat == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_gate) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s       <= '0;
            pc      <= '0;
            run_len <= '0;
            run_dir <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ld_data) begin
                        s <= data_in;
                    end
                    if (start) begin
                        run_len <= len_sat;
                        run_dir <= dir;
                        err_r   <= 1'b0;
                        pc      <= (dir && len_sat != '0) ? LD'(len_sat - (LD+1)'(1)) : '0;
                    end
                end
                S_RUN: begin
                    if (gate_illegal) begin
                        err_r <= 1'b1;
                    end else begin
                        s[t_idx] <= tof_y[2];
                    end
                    // Counter holds on the final gate rather than wrapping.
                    if (!last_gate) begin
                        pc <= run_dir ? (pc - LD'(1)) : (pc + LD'(1));
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Gate list is deliberately not reset; writes are accepted only while idle.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && ld_gate) begin
            glist[ld_addr] <= gate_in;
        end
    end

    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);
    assign err      = err_r;
    assign data_out = s;

endmodule

`default_nettype wire

// File: tb/tb_tof_sequencer.sv
// Scoreboard bench for tof_sequencer (W=8, DEPTH=8) with hand-computed vectors.
`default_nettype none

module tb_tof_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_gate = 1'b0;
    logic [2:0] ld_addr = '0;
    logic [8:0] gate_in = '0;
    logic       ld_data = 1'b0;
    logic [7:0] data_in = '0;
    logic [3:0] len = '0;
    logic       dir = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] data_out;

    tof_sequencer #(.W(8), .DEPTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_gate  (ld_gate),
        .ld_addr  (ld_addr),
        .gate_in  (gate_in),
        .ld_data  (ld_data),
        .data_in  (data_in),
        .len      (len),
        .dir      (dir),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   nc = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [8:0] g(input int t, input int c1, input int c0);
        return {3'(t), 3'(c1), 3'(c0)};
    endfunction

    // Monitor: pops the expected response whenever done is presented.
    always @(negedge clk) begin
        nc++;
        while (sb.size() > 0 && sb[0].cyc < nc) begin
            mon_e = sb.pop_front();
            chk("done_missing", nc, mon_e.cyc);
        end
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", nc, mon_e.cyc);
                chk("data_out", {24'd0, data_out}, {24'd0, mon_e.data});
                chk("err", {31'd0, err}, {31'd0, mon_e.err});
            end
        end
    end

    task automatic load_gate(input int addr, input logic [8:0] gv);
        @(posedge clk); #1;
        ld_gate = 1'b1;
        ld_addr = 3'(addr);
        gate_in = gv;
        @(posedge clk); #1;
        ld_gate = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    // Issues start (optionally with a same-cycle data/gate load) and queues the expected result.
    task automatic run(input int l, input logic d,
                       input logic do_ld, input logic [7:0] din,
                       input logic do_lg, input int gaddr, input logic [8:0] gv,
                       input logic [7:0] exp_data, input logic exp_err, input logic push);
        int   lsat;
        exp_t e;
        lsat = (l > 8) ? 8 : l;
        @(posedge clk); #1;
        start   = 1'b1;
        len     = 4'(l);
        dir     = d;
        ld_data = do_ld;
        data_in = din;
        ld_gate = do_lg;
        ld_addr = 3'(gaddr);
        gate_in = gv;
        if (push) begin
            e.cyc  = nc + lsat + 2;
            e.data = exp_data;
            e.err  = exp_err;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("busy_before_accept", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        start   = 1'b0;
        ld_data = 1'b0;
        ld_gate = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", {31'd0, busy}, {31'd0, (lsat > 0)});
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single gate: 0x03 -> 0x07, done two cycles after start
        load_gate(0, g(2, 1, 0));
        run(1, 1'b0, 1'b1, 8'h03, 1'b0, 0, '0, 8'h07, 1'b0, 1'b1);
        wait_drain();

        // Four legal gates, data loaded together with start: 0xA5 -> 0xFF -> 0xA5
        load_gate(0, g(3, 2, 0));
        load_gate(1, g(6, 7, 5));
        load_gate(2, g(1, 3, 6));
        load_gate(3, g(4, 0, 1));
        run(4, 1'b0, 1'b1, 8'hA5, 1'b0, 0, '0, 8'hFF, 1'b0, 1'b1);
        wait_drain();
        run(4, 1'b1, 1'b0, 8'h00, 1'b0, 0, '0, 8'hA5, 1'b0, 1'b1);
        wait_drain();

        // Illegal gate written in the same cycle as start: err set, data held
        run(1, 1'b0, 1'b0, 8'h00, 1'b1, 0, g(1, 1, 0), 8'hA5, 1'b1, 1'b1);
        wait_drain();
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Next start clears err; restores entry 0 at the same time
        run(1, 1'b0, 1'b0, 8'h00, 1'b1, 0, g(3, 2, 0), 8'hAD, 1'b0, 1'b1);
        wait_drain();

        // len = 0: done next cycle, busy never high, data unchanged
        run(0, 1'b0, 1'b0, 8'h00, 1'b0, 0, '0, 8'hAD, 1'b0, 1'b1);
        wait_drain();

        // len = 12 saturates to 8 entries: 0xFF -> 0x4F
        load_gate(4, g(7, 1, 0));
        load_gate(5, g(5, 2, 1));
        load_gate(6, g(3, 2, 0));
        load_gate(7, g(6, 3, 2));
        run(12, 1'b0, 1'b1, 8'hFF, 1'b0, 0, '0, 8'h4F, 1'b0, 1'b1);
        wait_drain();

        // Loads and start during RUN are ignored
        run(4, 1'b0, 1'b1, 8'hA5, 1'b0, 0, '0, 8'hFF, 1'b0, 1'b1);
        start   = 1'b1;
        len     = 4'd0;
        ld_data = 1'b1;
        data_in = 8'h00;
        ld_gate = 1'b1;
        ld_addr = 3'd1;
        gate_in = g(1, 1, 0);
        @(posedge clk); #1;
        start   = 1'b0;
        ld_data = 1'b0;
        ld_gate = 1'b0;
        wait_drain();
        run(4, 1'b1, 1'b0, 8'h00, 1'b0, 0, '0, 8'hA5, 1'b0, 1'b1);
        wait_drain();

        // Reset on the second RUN cycle of a len=4 run: abort, no done
        run(4, 1'b0, 1'b0, 8'h00, 1'b0, 0, '0, 8'h00, 1'b0, 1'b0);
        chk("busy_mid_run", {31'd0, busy}, 32'd1);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_data_out", {24'd0, data_out}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_idle_busy", {31'd0, busy}, 32'd0);
        chk("abort_idle_data", {24'd0, data_out}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tof_sequencer.md
TOF_SEQUENCER -- requirements
Module: tof_sequencer

Interface
REQ-001 Parameter W, default 8: width of the reversible state register; a power of two, at least 4.
REQ-002 Parameter DEPTH, default 8: gate-list entries; a power of two.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 ld_gate  in  1  write gate_in into gate list entry ld_addr; honoured only in IDLE.
REQ-006 ld_addr  in  log2(DEPTH)  gate list write address.
REQ-007 gate_in  in  3*log2(W)  gate entry {t, c1, c0}: bit indices for target, control 1 and control 0.
REQ-008 ld_data  in  1  load data_in into the state register; honoured only in IDLE.
REQ-009 data_in  in  W  initial register value.
REQ-010 len  in  log2(DEPTH)+1  number of gates to execute; sampled on start.
REQ-011 dir  in  1  0 = forward (entry 0..len-1), 1 = reverse (entry len-1..0); sampled on start.
REQ-012 start  in  1  begin a run; honoured only in IDLE.
REQ-013 busy  out  1  high while in RUN.
REQ-014 done  out  1  single-cycle pulse when a run completes.
REQ-015 err  out  1  sticky flag for an illegal gate; cleared by the next accepted start.
REQ-016 data_out  out  W  current state register.

Function
REQ-017 States: IDLE, RUN, DONE. IDLE->RUN on start with len>0. IDLE->DONE on start with len=0. RUN->DONE after the last gate. DONE->IDLE unconditionally.
REQ-018 In RUN, one gate is applied per cycle: s[t] <= s[t] ^ (s[c0] & s[c1]). All other bits are held.
REQ-019 Gate evaluation goes through one tof sub-instance: inputs {s[t], s[c1], s[c0]}; the output top bit is written back to s[t].
REQ-020 Illegal gate (t==c0, t==c1, or the entry index is >= len): state is unchanged, err is set, and execution continues.
REQ-021 Latency: done asserts exactly len+1 cycles after the cycle in which start is accepted; done is also asserted for len=0.
REQ-022 len > DEPTH is saturated to DEPTH.
REQ-023 Program counter: forward counts 0 up; reverse starts at len-1 and counts down; no wrap-around past the end.
REQ-024 In IDLE with ld_data and start asserted together: the register loads data_in and the run starts on the next cycle using the loaded value.
REQ-025 In IDLE with ld_gate and start asserted together: the write takes effect before the first gate fetch.
REQ-026 ld_gate, ld_data and start are ignored outside IDLE; gate list and state are unaffected.
REQ-027 Reversibility: a forward run followed by a reverse run with the same list and len restores the original data_out.

Reset
REQ-028 When rst_n is low at a clock edge: state returns to IDLE; data_out = 0; busy = 0; done = 0; err = 0; the program counter is cleared.
REQ-029 The gate list is not reset; its contents are undefined until written.
REQ-030 Reset asserted mid-RUN aborts the run with no done pulse; outputs reach reset values on that edge.

Structure
REQ-031 A shared package holds the FSM state encoding, the gate-entry field offsets, and the default W/DEPTH constants.
REQ-032 The sole sub-module is the existing three-bit Toffoli gate, instantiated once; the gate list is a register array inside tof_sequencer.

Verification
REQ-033 W=8. Load 0x03; gate {t=2,c1=1,c0=0}; len=1, forward -> data_out=0x07; done 2 cycles after start; err=0.
REQ-034 Load 0xA5; 4 distinct legal gates; forward, then reverse -> data_out returns to 0xA5.
REQ-035 Gate {t=1,c1=1,c0=0}; len=1 -> err=1; data_out unchanged; done pulses.
REQ-036 len=0 start -> done the next cycle; busy never high; data_out unchanged.
REQ-037 rst_n low on the 2nd RUN cycle of a len=4 run -> IDLE; data_out=0; no done pulse.
REQ-038 ld_gate and start pulsed during RUN -> ignored; the run result matches the golden model.
